// File: rtl/dff_pkg.sv
// Shared types and defaults for the input-conditioning stage
// ahead of the D flip-flop.
package dff_pkg;

  typedef enum logic [1:0] {
    ST_LOW,
    WAIT_HIGH,
    ST_HIGH,
    WAIT_LOW
  } db_state_t;

  localparam int DB_SYNC_STAGES_DEF   = 2;
  localparam int DB_STABLE_CYCLES_DEF = 4;

endpackage

// File: rtl/debounce_sync_if.sv
// Raw input and conditioned outputs of debounce_sync.
// master = consumer/driver of din, slave = the debouncer.
interface debounce_sync_if;
  logic din;
  logic d;
  logic rise;
  logic fall;
  logic busy;

  modport master (
    output din,
    input  d,
    input  rise,
    input  fall,
    input  busy
  );

  modport slave (
    input  din,
    output d,
    output rise,
    output fall,
    output busy
  );
endinterface

// File: rtl/debounce_sync_sync_chain.sv
// Plain flop-chain synchroniser for any asynchronous
// single-bit input; all stages clear on reset.
module sync_chain #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[DEPTH-2:0], din};
    end
  end

  assign dout = sync_q[DEPTH-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronise a raw input, then accept a level change only after
// STABLE_CYCLES identical samples; emit one-cycle edge pulses.
module debounce_sync
  import dff_pkg::*;
#(
  parameter int SYNC_STAGES   = DB_SYNC_STAGES_DEF,
  parameter int STABLE_CYCLES = DB_STABLE_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            reset,
  debounce_sync_if.slave  io
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic          s;
  db_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          d_q, d_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          busy_q, busy_d;

  sync_chain #(
    .DEPTH (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (io.din),
    .dout  (s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_LOW;
      cnt_q   <= '0;
      d_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  // Any opposing sample while waiting drops back to the old level.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_LOW: begin
        if (s) begin
          state_d = WAIT_HIGH;
          cnt_d   = CW'(1);
        end else begin
          cnt_d = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HIGH: begin
        if (!s) begin
          state_d = WAIT_LOW;
          cnt_d   = CW'(1);
        end else begin
          cnt_d = '0;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    rise_d = (state_q == WAIT_HIGH) && (state_d == ST_HIGH);
    fall_d = (state_q == WAIT_LOW) && (state_d == ST_LOW);
    busy_d = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
    d_d    = d_q;
    if (rise_d) d_d = 1'b1;
    if (fall_d) d_d = 1'b0;
  end

  assign io.d    = d_q;
  assign io.rise = rise_q;
  assign io.fall = fall_q;
  assign io.busy = busy_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Scenario bench for debounce_sync: expected pulses are queued with
// their due cycle and matched against pulses seen on the outputs.
module tb_debounce_sync;

  typedef struct packed {
    logic [1:0] kind;
    int         cyc;
  } ev_t;

  localparam logic [1:0] K_RISE = 2'b01;
  localparam logic [1:0] K_FALL = 2'b10;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  ev_t  exp_q[$];
  ev_t  obs_q[$];

  debounce_sync_if ifc ();

  debounce_sync #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (4)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .io    (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ifc.rise || ifc.fall)
      obs_q.push_back('{kind: {ifc.fall, ifc.rise}, cyc: cyc});
  end

  task automatic test_reset();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      ifc.din = k[0];
      checks++;
      if ({ifc.d, ifc.rise, ifc.fall, ifc.busy} !== 4'b0) begin
        errors++;
        $display("FAIL reset_hold k=%0d got d/r/f/b=%b%b%b%b want 0000",
                 k, ifc.d, ifc.rise, ifc.fall, ifc.busy);
      end
    end
    @(negedge clk);
    ifc.din = 1'b0;
    rst_n   = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if ({ifc.d, ifc.rise, ifc.fall, ifc.busy} !== 4'b0) begin
        errors++;
        $display("FAIL reset_idle k=%0d got d/r/f/b=%b%b%b%b want 0000",
                 k, ifc.d, ifc.rise, ifc.fall, ifc.busy);
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL reset_pulses got %0d pulses want 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_glitch();
    int   n;
    logic be;
    @(negedge clk);
    n = cyc;
    ifc.din = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 2) ifc.din = 1'b0;
      be = (k >= 3 && k <= 4);
      checks++;
      if (ifc.busy !== be || ifc.d !== 1'b0) begin
        errors++;
        $display("FAIL glitch k=%0d busy=%b want %b d=%b want 0",
                 k, ifc.busy, be, ifc.d);
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL glitch_pulses got %0d pulses want 0 (start %0d)",
               obs_q.size(), n);
    end
    obs_q.delete();
  endtask

  task automatic test_clean_rise();
    int   n;
    logic be, de;
    ev_t  e, o;
    @(negedge clk);
    n = cyc;
    ifc.din = 1'b1;
    exp_q.push_back('{kind: K_RISE, cyc: n + 6});
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      be = (k >= 3 && k <= 5);
      de = (k >= 6);
      checks++;
      if (ifc.busy !== be || ifc.d !== de) begin
        errors++;
        $display("FAIL rise_lvl k=%0d busy=%b want %b d=%b want %b",
                 k, ifc.busy, be, ifc.d, de);
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL rise_ev got none want kind=%b cyc=%0d", e.kind, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL rise_ev got kind=%b cyc=%0d want kind=%b cyc=%0d",
                   o.kind, o.cyc, e.kind, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL rise_extra got %0d extra pulses want 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_clean_fall();
    int   n;
    logic be, de;
    ev_t  e, o;
    @(negedge clk);
    n = cyc;
    ifc.din = 1'b0;
    exp_q.push_back('{kind: K_FALL, cyc: n + 6});
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      be = (k >= 3 && k <= 5);
      de = (k < 6);
      checks++;
      if (ifc.busy !== be || ifc.d !== de) begin
        errors++;
        $display("FAIL fall_lvl k=%0d busy=%b want %b d=%b want %b",
                 k, ifc.busy, be, ifc.d, de);
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL fall_ev got none want kind=%b cyc=%0d", e.kind, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL fall_ev got kind=%b cyc=%0d want kind=%b cyc=%0d",
                   o.kind, o.cyc, e.kind, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL fall_extra got %0d extra pulses want 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_bounce();
    int   n;
    logic be, de;
    ev_t  e, o;
    @(negedge clk);
    n = cyc;
    ifc.din = 1'b1;
    // three good samples, one opposing, then a full restart
    exp_q.push_back('{kind: K_RISE, cyc: n + 4 + 6});
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k == 3) ifc.din = 1'b0;
      if (k == 4) ifc.din = 1'b1;
      be = (k >= 3 && k <= 5) || (k >= 7 && k <= 9);
      de = (k >= 10);
      checks++;
      if (ifc.busy !== be || ifc.d !== de) begin
        errors++;
        $display("FAIL bounce_lvl k=%0d busy=%b want %b d=%b want %b",
                 k, ifc.busy, be, ifc.d, de);
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL bounce_ev got none want kind=%b cyc=%0d", e.kind, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL bounce_ev got kind=%b cyc=%0d want kind=%b cyc=%0d",
                   o.kind, o.cyc, e.kind, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL bounce_extra got %0d extra pulses want 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_back_to_back();
    int   n;
    logic de;
    ev_t  e, o;
    @(negedge clk);
    n = cyc;
    ifc.din = 1'b1;
    exp_q.push_back('{kind: K_RISE, cyc: n + 6});
    exp_q.push_back('{kind: K_FALL, cyc: n + 12});
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 6) ifc.din = 1'b0;
      de = (k >= 6 && k < 12);
      checks++;
      if (ifc.d !== de) begin
        errors++;
        $display("FAIL b2b_lvl k=%0d d=%b want %b", k, ifc.d, de);
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL b2b_ev got none want kind=%b cyc=%0d", e.kind, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL b2b_ev got kind=%b cyc=%0d want kind=%b cyc=%0d",
                   o.kind, o.cyc, e.kind, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_extra got %0d extra pulses want 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_reset_mid();
    int   m;
    logic be, de;
    ev_t  e, o;
    @(negedge clk);
    ifc.din = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (ifc.busy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre busy=%b want 1", ifc.busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ifc.d, ifc.rise, ifc.fall, ifc.busy} !== 4'b0) begin
      errors++;
      $display("FAIL rstmid_async got d/r/f/b=%b%b%b%b want 0000",
               ifc.d, ifc.rise, ifc.fall, ifc.busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL rstmid_pulse got %0d pulses want 0", obs_q.size());
    end
    obs_q.delete();
    m = cyc;
    rst_n = 1'b1;
    exp_q.push_back('{kind: K_RISE, cyc: m + 6});
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      be = (k >= 3 && k <= 5);
      de = (k >= 6);
      checks++;
      if (ifc.busy !== be || ifc.d !== de) begin
        errors++;
        $display("FAIL rstmid_lvl k=%0d busy=%b want %b d=%b want %b",
                 k, ifc.busy, be, ifc.d, de);
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL rstmid_ev got none want kind=%b cyc=%0d", e.kind, e.cyc);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL rstmid_ev got kind=%b cyc=%0d want kind=%b cyc=%0d",
                   o.kind, o.cyc, e.kind, e.cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL rstmid_extra got %0d extra pulses want 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    ifc.din = 1'b0;
    test_reset();
    test_glitch();
    test_clean_rise();
    test_clean_fall();
    test_bounce();
    test_clean_fall();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounce_sync.md
# debounce_sync

Conditions a raw asynchronous single-bit input (push-button or external strobe) into a clean, glitch-free level on `clk`. This is the stage directly upstream of the D flip-flop: its `d` output drives the flip-flop's `d` pin. The block synchronises the raw input through a flop chain. It then requires the synchronised value to hold for a programmable number of consecutive cycles before changing the output level. On each accepted change it also emits a one-cycle edge pulse.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchroniser depth; legal range 2..4.
- `STABLE_CYCLES`, 4: number of consecutive identical synchronised samples required to accept a change; legal range 2..65535.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset; 0 = reset asserted.
- `din`  in  1  raw asynchronous input; may glitch at any time.
- `d`  out  1  debounced level; feeds the downstream flip-flop `d` input.
- `rise`  out  1  one-cycle pulse when `d` goes 0->1.
- `fall`  out  1  one-cycle pulse when `d` goes 1->0.
- `busy`  out  1  high while a candidate change is being qualified.

## Operation
- The synchroniser is a chain of `SYNC_STAGES` flops, all reset to 0. Its last stage is `s`.
- The qualification counter `cnt` is `$clog2(STABLE_CYCLES+1)` bits wide, resets to 0, and saturates by construction because it never exceeds `STABLE_CYCLES-1`.
- FSM states: `ST_LOW`, `WAIT_HIGH`, `ST_HIGH`, `WAIT_LOW`. Reset state is `ST_LOW`.
- `ST_LOW`:
  - `s`=1 -> `WAIT_HIGH`, `cnt`<=1.
  - Otherwise hold, `cnt`<=0.
- `WAIT_HIGH`:
  - `s`=0 -> `ST_LOW`, `cnt`<=0, no pulse.
  - Else if `cnt`==`STABLE_CYCLES-1` -> `ST_HIGH`, `d`<=1, `rise`<=1, `cnt`<=0.
  - Else `cnt`<=`cnt`+1.
- `ST_HIGH` / `WAIT_LOW`: mirror of the above with polarity inverted; the accepted change drives `d`<=0 and `fall`<=1.
- `busy` is high exactly in the `WAIT_HIGH` and `WAIT_LOW` states.
- All outputs are registered; none is combinational from `din`.
- `rise` and `fall` are never high in the same cycle. Each is high for exactly one cycle per accepted transition.

## Timing
- Reset values (asynchronous, immediate on `reset`=0): `d`=0, `rise`=0, `fall`=0, `busy`=0, `cnt`=0, synchroniser=0, state `ST_LOW`.
- Latency: count the clock edge at which the first synchroniser flop captures the new `din` value as edge 1. Then `d`, together with the `rise`/`fall` pulse, updates on edge `SYNC_STAGES+STABLE_CYCLES`. With defaults, this is edge 6.
- A pulse on `din` that lasts fewer than `STABLE_CYCLES` synchronised samples produces no change on `d` and no pulse. `busy` rises and falls back.
- Glitch in mid-qualification: any single opposing sample in `WAIT_*` aborts qualification. The next qualification restarts from `cnt`=1.
- Back-to-back changes: the earliest new qualification can begin is the cycle after the `rise`/`fall` pulse. The minimum spacing between accepted transitions is `STABLE_CYCLES` cycles.
- Reset mid-qualification: all state clears immediately and no pulse is emitted.
- Reset release with `din` held at 1: the block performs a full qualification from `ST_LOW`, and `rise` fires at the nominal latency measured from the first post-release edge.
- Reset release is assumed synchronous to `clk` at the system level. The block does not re-synchronise `reset`.

## Structure
- The shared package `dff_pkg` holds:
  - the FSM state enum `db_state_t`: `ST_LOW`, `WAIT_HIGH`, `ST_HIGH`, `WAIT_LOW`;
  - the localparam defaults `DB_SYNC_STAGES_DEF`=2 and `DB_STABLE_CYCLES_DEF`=4.
- Sub-module `sync_chain`:
  - parameterised on depth, with `clk`, `reset`, `din` and `dout` ports;
  - reused for every other asynchronous input in the design.
- The FSM and counter live in `debounce_sync` itself.

## Test plan
- Reset behaviour: hold `reset`=0 with `din` toggling -> `d`=`rise`=`fall`=`busy`=0 throughout. After release with `din`=0 -> outputs stay at 0.
- Clean rise: with defaults, set `din`=1 just before edge 1 and hold -> `busy`=1 from edge 3, `d`=1 and `rise`=1 after edge 6, `rise`=0 after edge 7. `fall` is never asserted.
- Glitch reject: `din` high for 2 cycles, then low -> `busy` pulses, `d` stays 0, and `rise`/`fall` stay 0.
- Mid-qualification bounce: `din`=1 for 3 cycles, 0 for 1 cycle, then 1 held -> `rise` fires exactly 4 synchronised-high cycles after the bounce ends, not earlier.
- Clean fall: from `d`=1, drop `din` and hold -> `d`=0 and a single `fall` pulse after edge 6. `rise` stays 0.
- Reset during `WAIT_HIGH`: assert `reset`=0 at `cnt`=2 -> all outputs are 0 immediately. Release with `din`=1 -> `rise` fires at the full nominal latency.
